// File: rtl/mole_round_ctrl_pkg.sv
// Shared state encodings and LFSR constants for the whack-a-mole round scheduler.
// No logic; imported by the controller and its interface users.
package mole_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_UP     = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Game-side bundle for the round scheduler: enable and whacks in, mole lines, result pulses and score out.
// Plain level/pulse signals, no backpressure.
interface mole_round_ctrl_if #(
    parameter int N_MOLES = 4,
    parameter int SCORE_W = 8
);
    logic               game_en;
    logic [N_MOLES-1:0] hit_in;
    logic [N_MOLES-1:0] mole_up;
    logic               hit;
    logic               miss;
    logic               game_over;
    logic [SCORE_W-1:0] score;
    logic [7:0]         round_idx;

    modport master (
        output game_en, hit_in,
        input  mole_up, hit, miss, game_over, score, round_idx
    );

    modport slave (
        input  game_en, hit_in,
        output mole_up, hit, miss, game_over, score, round_idx
    );
endinterface

// File: rtl/mole_round_ctrl_tick_divider.sv
// Prescaler plus tick counter; done is combinational and high on the last cycle of a K-tick dwell.
// clr restarts the dwell on the next edge; no backpressure.
module mole_round_ctrl_tick_divider #(
    parameter int TICK_CYCLES = 50000,
    parameter int TICK_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [TICK_W-1:0] k,
    output logic              done
);
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    logic [PRE_W-1:0]  pre_q;
    logic [TICK_W-1:0] tick_q;
    logic              pre_wrap;

    assign pre_wrap = (pre_q == PRE_LAST);
    assign done     = pre_wrap && (tick_q == k - TICK_W'(1));

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            pre_q  <= '0;
            tick_q <= '0;
        end else if (pre_wrap) begin
            pre_q  <= '0;
            tick_q <= tick_q + TICK_W'(1);
        end else begin
            pre_q  <= pre_q + PRE_W'(1);
        end
    end
endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round scheduler: gap, random mole, wait for hit/timeout; result pulses one cycle after the deciding edge.
// Outputs are registered; no backpressure, game_en low aborts to IDLE.
import mole_round_ctrl_pkg::*;

module mole_round_ctrl #(
    parameter int N_MOLES     = 4,
    parameter int TICK_CYCLES = 50000,
    parameter int GAP_TICKS   = 250,
    parameter int UP_TICKS    = 1000,
    parameter int ROUNDS      = 16,
    parameter int SCORE_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    mole_round_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(N_MOLES);
    localparam int MAX_K  = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
    localparam int TICK_W = $clog2(MAX_K + 1);
    localparam int unsigned LAST_ROUND = ROUNDS - 1;

    state_t             state_q;
    logic [15:0]        lfsr_q;
    logic [N_MOLES-1:0] mole_up_q;
    logic               hit_q;
    logic               miss_q;
    logic               game_over_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic [7:0]         round_idx_q;
    logic [IDX_W-1:0]   prev_idx_q;
    logic               prev_vld_q;

    logic               dwell_done;
    logic               tmr_clr;
    logic [TICK_W-1:0]  dwell_k;
    logic               wrong_hit;
    logic               right_hit;
    logic [IDX_W-1:0]   idx_raw;
    logic [IDX_W-1:0]   idx_sel;

    assign wrong_hit = |(bus.hit_in & ~mole_up_q);
    assign right_hit = |(bus.hit_in & mole_up_q);
    assign idx_raw   = lfsr_q[IDX_W-1:0];
    assign idx_sel   = (prev_vld_q && (idx_raw == prev_idx_q)) ? idx_raw + IDX_W'(1) : idx_raw;
    assign score_d   = (&score_q) ? score_q : score_q + SCORE_W'(1);
    assign dwell_k   = (state_q == ST_UP) ? TICK_W'(UP_TICKS) : TICK_W'(GAP_TICKS);

    // The timebase restarts on exactly the edges where the FSM changes state.
    always_comb begin
        tmr_clr = 1'b0;
        case (state_q)
            ST_IDLE:   tmr_clr = bus.game_en;
            ST_GAP:    tmr_clr = !bus.game_en || dwell_done;
            ST_UP:     tmr_clr = !bus.game_en || dwell_done || (|bus.hit_in);
            ST_RESULT: tmr_clr = 1'b1;
        endcase
    end

    mole_round_ctrl_tick_divider #(
        .TICK_CYCLES (TICK_CYCLES),
        .TICK_W      (TICK_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .k     (dwell_k),
        .done  (dwell_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            mole_up_q   <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
            score_q     <= '0;
            round_idx_q <= '0;
            prev_idx_q  <= '0;
            prev_vld_q  <= 1'b0;
        end else begin
            lfsr_q      <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mole_up_q <= '0;
                    if (bus.game_en) begin
                        score_q     <= '0;
                        round_idx_q <= '0;
                        prev_vld_q  <= 1'b0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!bus.game_en) begin
                        state_q <= ST_IDLE;
                    end else if (dwell_done) begin
                        mole_up_q  <= N_MOLES'(1) << idx_sel;
                        prev_idx_q <= idx_sel;
                        prev_vld_q <= 1'b1;
                        state_q    <= ST_UP;
                    end
                end
                ST_UP: begin
                    if (!bus.game_en) begin
                        mole_up_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (wrong_hit || right_hit || dwell_done) begin
                        mole_up_q <= '0;
                        state_q   <= ST_RESULT;
                        if (!wrong_hit && right_hit) begin
                            hit_q   <= 1'b1;
                            score_q <= score_d;
                        end else begin
                            miss_q  <= 1'b1;
                        end
                    end
                end
                ST_RESULT: begin
                    if (!bus.game_en) begin
                        state_q <= ST_IDLE;
                    end else if (32'(round_idx_q) == LAST_ROUND) begin
                        game_over_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        round_idx_q <= round_idx_q + 8'd1;
                        state_q     <= ST_GAP;
                    end
                end
            endcase
        end
    end

    assign bus.mole_up   = mole_up_q;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.game_over = game_over_q;
    assign bus.score     = score_q;
    assign bus.round_idx = round_idx_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: expected result pulses are queued by the stimulus and checked by a monitor.
module tb_mole_round_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mole_round_ctrl_if #(.N_MOLES(4), .SCORE_W(8)) bus ();
    mole_round_ctrl_if #(.N_MOLES(4), .SCORE_W(8)) bus2 ();

    mole_round_ctrl #(
        .N_MOLES(4), .TICK_CYCLES(4), .GAP_TICKS(2), .UP_TICKS(5), .ROUNDS(3), .SCORE_W(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    mole_round_ctrl #(
        .N_MOLES(4), .TICK_CYCLES(4), .GAP_TICKS(2), .UP_TICKS(5), .ROUNDS(300), .SCORE_W(8)
    ) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );

    int total = 0;
    int bad   = 0;
    int n_rep = 0;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] score;
        logic [7:0] rnd;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [2:0] K_HIT  = 3'b001;
    localparam logic [2:0] K_MISS = 3'b010;
    localparam logic [2:0] K_GO   = 3'b100;

    // Independent LFSR reference: value held before each edge is kept in m_prev.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    logic [1:0] prev_idx = 2'd0;
    logic       prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.hit || bus.miss || bus.game_over) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, bus.game_over, bus.miss, bus.hit}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pulse_kind", {29'd0, bus.game_over, bus.miss, bus.hit}, {29'd0, e.kind});
                chk("pulse_score", {24'd0, bus.score}, {24'd0, e.score});
                chk("pulse_round", {24'd0, bus.round_idx}, {24'd0, e.rnd});
                chk("pulse_mole_down", {28'd0, bus.mole_up}, 32'd0);
            end
        end
        if (bus2.miss || bus2.game_over)
            chk("sat_unexpected_pulse", {30'd0, bus2.game_over, bus2.miss}, 32'd0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [7:0] score, input logic [7:0] rnd);
        exp_t e;
        e.kind = kind;
        e.score = score;
        e.rnd = rnd;
        sb_q.push_back(e);
    endtask

    task automatic wait_mole(output logic [3:0] mole);
        int zeros;
        logic [1:0] ei;
        zeros = 0;
        mole = 4'd0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.mole_up != 4'd0) begin
                mole = bus.mole_up;
                break;
            end
            zeros++;
        end
        chk("gap_len", zeros, 8);
        if (mole != 4'd0) begin
            ei = m_prev[1:0];
            if (prev_vld && ei == prev_idx) begin
                ei = ei + 2'd1;
                n_rep++;
            end
            chk("mole_sel", {28'd0, mole}, {28'd0, 4'b0001 << ei});
            if (prev_vld)
                chk("mole_no_repeat", {31'd0, mole == (4'b0001 << prev_idx)}, 32'd0);
            prev_idx = ei;
            prev_vld = 1'b1;
        end
    endtask

    task automatic pulse_hit(input logic [3:0] v);
        bus.hit_in = v;
        cyc(1);
        bus.hit_in = 4'd0;
    endtask

    task automatic start_game();
        prev_vld = 1'b0;
        bus.game_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mole;
        logic [3:0] m2;
        int up;
        bus.game_en = 1'b0;
        bus.hit_in = 4'd0;
        bus2.game_en = 1'b0;
        bus2.hit_in = 4'd0;
        cyc(3);
        chk("rst_mole", {28'd0, bus.mole_up}, 32'd0);
        chk("rst_pulses", {29'd0, bus.game_over, bus.miss, bus.hit}, 32'd0);
        chk("rst_score", {24'd0, bus.score}, 32'd0);
        chk("rst_round", {24'd0, bus.round_idx}, 32'd0);
        reset = 1'b1;
        cyc(2);

        // Game 1: hit, timeout, wrong+correct then game over.
        start_game();
        wait_mole(mole);
        push(K_HIT, 8'd1, 8'd0);
        pulse_hit(mole);
        chk("hit_mole_down", {28'd0, bus.mole_up}, 32'd0);

        wait_mole(mole);
        push(K_MISS, 8'd1, 8'd1);
        up = 1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.mole_up == 4'd0) break;
            up++;
        end
        chk("up_len", up, 20);

        wait_mole(mole);
        chk("round_idx_2", {24'd0, bus.round_idx}, 32'd2);
        push(K_MISS, 8'd1, 8'd2);
        push(K_GO, 8'd1, 8'd2);
        pulse_hit(mole | {mole[2:0], mole[3]});
        cyc(1);
        chk("game_over_seen", {31'd0, bus.game_over}, 32'd1);
        bus.game_en = 1'b0;
        cyc(4);
        chk("idle_score_hold", {24'd0, bus.score}, 32'd1);
        chk("idle_round_hold", {24'd0, bus.round_idx}, 32'd2);
        chk("idle_mole", {28'd0, bus.mole_up}, 32'd0);

        // Game 2: correct hit on the timeout cycle, then abort mid-UP.
        start_game();
        wait_mole(mole);
        chk("new_game_score", {24'd0, bus.score}, 32'd0);
        chk("new_game_round", {24'd0, bus.round_idx}, 32'd0);
        cyc(19);
        chk("mole_up_last_cycle", {31'd0, bus.mole_up != 4'd0}, 32'd1);
        push(K_HIT, 8'd1, 8'd0);
        pulse_hit(mole);

        wait_mole(mole);
        cyc(3);
        bus.game_en = 1'b0;
        cyc(1);
        chk("abort_mole", {28'd0, bus.mole_up}, 32'd0);
        cyc(25);
        chk("abort_score_hold", {24'd0, bus.score}, 32'd1);

        // Game 3: reset during round 1 gap.
        start_game();
        wait_mole(mole);
        push(K_HIT, 8'd1, 8'd0);
        pulse_hit(mole);
        cyc(3);
        chk("pre_reset_round", {24'd0, bus.round_idx}, 32'd1);
        reset = 1'b0;
        cyc(1);
        chk("midrst_mole", {28'd0, bus.mole_up}, 32'd0);
        chk("midrst_score", {24'd0, bus.score}, 32'd0);
        chk("midrst_round", {24'd0, bus.round_idx}, 32'd0);
        chk("midrst_pulses", {29'd0, bus.game_over, bus.miss, bus.hit}, 32'd0);
        bus.game_en = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(2);

        // Games 4-6: three straight hits each, exercising mole selection.
        for (int g = 0; g < 3; g++) begin
            start_game();
            for (int r = 0; r < 3; r++) begin
                wait_mole(mole);
                push(K_HIT, 8'(r + 1), 8'(r));
                if (r == 2) push(K_GO, 8'd3, 8'd2);
                pulse_hit(mole);
            end
            cyc(1);
            bus.game_en = 1'b0;
            cyc(3);
            chk("full_game_score", {24'd0, bus.score}, 32'd3);
        end
        $display("info: mole repeats redirected = %0d", n_rep);

        // Saturating score on the long-game instance.
        bus2.game_en = 1'b1;
        for (int i = 0; i < 260; i++) begin
            m2 = 4'd0;
            for (int j = 0; j < 100 && m2 == 4'd0; j++) begin
                cyc(1);
                m2 = bus2.mole_up;
            end
            chk("sat_mole_up", {31'd0, m2 != 4'd0}, 32'd1);
            if (m2 == 4'd0) break;
            bus2.hit_in = m2;
            cyc(1);
            bus2.hit_in = 4'd0;
            if (i == 253) chk("sat_score_fe", {24'd0, bus2.score}, 32'hFE);
            if (i == 254) chk("sat_score_ff", {24'd0, bus2.score}, 32'hFF);
        end
        chk("sat_score_hold", {24'd0, bus2.score}, 32'hFF);
        bus2.game_en = 1'b0;
        cyc(3);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
